// File: rtl/logic_unit_seq.sv
// rtl/logic_unit_seq.sv - multi-cycle sliced AND/OR/XOR/NOT unit; optional parity via LOGIC_UNIT_SEQ_PARITY_EN
module logic_unit_seq #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             zero
`ifdef LOGIC_UNIT_SEQ_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int STEPS = WIDTH / SLICE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic [31:0]      base;
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] sr;
    logic             last_step;

    assign last_step = (cnt == CW'(STEPS - 1));

    // One slice of the latched operands is evaluated and merged into the result image
    always_comb begin
        res_next = res_q;
        base     = 32'(cnt) * SLICE;
        sa       = a_q[base +: SLICE];
        sb       = b_q[base +: SLICE];
        case (op_q)
            2'b00:   sr = sa & sb;
            2'b01:   sr = sa | sb;
            2'b10:   sr = sa ^ sb;
            default: sr = ~sa;
        endcase
        res_next[base +: SLICE] = sr;
    end

    // Control FSM, operand capture and result/flag registers; outputs only move at completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            res_q  <= '0;
            y      <= '0;
            zero   <= 1'b0;
`ifdef LOGIC_UNIT_SEQ_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        cnt   <= '0;
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    res_q <= res_next;
                    if (last_step) begin
                        y      <= res_next;
                        zero   <= (res_next == '0);
`ifdef LOGIC_UNIT_SEQ_PARITY_EN
                        parity <= ^res_next;
`endif
                        cnt    <= '0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb/tb_logic_unit_seq.sv - self-checking bench for logic_unit_seq
module tb_logic_unit_seq;

    localparam int W     = 8;
    localparam int S     = 2;
    localparam int STEPS = W / S;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         zero;
    logic         parity;

    logic         start1 = 1'b0;
    logic [1:0]   op1 = 2'b00;
    logic [0:0]   a1 = '0;
    logic [0:0]   b1 = '0;
    logic         busy1;
    logic         done1;
    logic [0:0]   y1;
    logic         zero1;
    logic         parity1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    logic_unit_seq #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .zero(zero)
`ifdef LOGIC_UNIT_SEQ_PARITY_EN
        , .parity(parity)
`endif
    );

    logic_unit_seq #(.WIDTH(1), .SLICE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .y(y1), .zero(zero1)
`ifdef LOGIC_UNIT_SEQ_PARITY_EN
        , .parity(parity1)
`endif
    );

`ifndef LOGIC_UNIT_SEQ_PARITY_EN
    assign parity  = 1'b0;
    assign parity1 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] logic_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        case (o)
            2'b00:   return x & z;
            2'b01:   return x | z;
            2'b10:   return x ^ z;
            default: return ~x;
        endcase
    endfunction

    // Timing-level reference: a request is taken when none is in flight, and its
    // result appears exactly STEPS edges after the accepting edge.
    int           e_n = 0;
    int           m_done_at = -1;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] ey = '0;
    logic         ez = 1'b0;
    logic         ep = 1'b0;
    logic         ebusy = 1'b0;
    logic         edone = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done_at = -1;
            ey = '0; ez = 1'b0; ep = 1'b0; ebusy = 1'b0; edone = 1'b0;
        end else begin
            e_n = e_n + 1;
            edone = (e_n == m_done_at);
            if (edone) begin
                ey = m_res;
                ez = (m_res == '0);
                ep = ^m_res;
            end
            if (!ebusy && start) begin
                m_res     = logic_op(op, a, b);
                m_done_at = e_n + STEPS;
            end
            ebusy = (m_done_at > e_n);
        end
    end

    // Every-cycle comparison against the reference
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(ebusy));
        chk("done", 32'(done), 32'(edone));
        chk("y", 32'(y), 32'(ey));
        chk("zero", 32'(zero), 32'(ez));
`ifdef LOGIC_UNIT_SEQ_PARITY_EN
        chk("parity", 32'(parity), 32'(ep));
`endif
    end

    task automatic go(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = z;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    int ndone;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_y", 32'(y), 32'h00);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 32'(busy), 32'd0);

        // AND: y holds old value while busy
        go(2'b00, 8'hF0, 8'h3C);
        chk("and_hold_y", 32'(y), 32'h00);
        chk("and_busy", 32'(busy), 32'd1);
        wait_done("and");
        chk("and_y", 32'(y), 32'h30);
        chk("and_zero", 32'(zero), 32'd0);
`ifdef LOGIC_UNIT_SEQ_PARITY_EN
        chk("and_parity", 32'(parity), 32'd0);
`endif

        // Asynchronous reset between edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_y", 32'(y), 32'h00);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // XOR then NOT back-to-back
        go(2'b10, 8'hAA, 8'hAA);
        wait_done("xor");
        chk("xor_y", 32'(y), 32'h00);
        chk("xor_zero", 32'(zero), 32'd1);
        start = 1'b1; op = 2'b11; a = 8'h5A; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done("not");
        chk("not_y", 32'(y), 32'hA5);
        chk("not_zero", 32'(zero), 32'd0);

        // start during BUSY is ignored
        go(2'b01, 8'h0F, 8'hF0);
        start = 1'b1; op = 2'b00; a = 8'h00; b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("ignore_ndone", 32'(ndone), 32'd1);
        chk("ignore_y", 32'(y), 32'hFF);

        // Reset on the second BUSY cycle aborts
        go(2'b01, 8'h01, 8'h02);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_y", 32'(y), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_ndone", 32'(ndone), 32'd0);
        chk("abort_y_after", 32'(y), 32'h00);

        // WIDTH=1 SLICE=1 AND truth table
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            @(negedge clk);
            start1 = 1'b1; op1 = 2'b00; a1 = ab[1]; b1 = ab[0];
            @(negedge clk);
            start1 = 1'b0;
            chk("tt_busy", 32'(busy1), 32'd1);
            chk("tt_nodone", 32'(done1), 32'd0);
            @(negedge clk);
            chk("tt_done", 32'(done1), 32'd1);
            chk("tt_y", 32'(y1), (i == 3) ? 32'd1 : 32'd0);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
